traffic_phase_controller: RTL
=============================

# traffic_phase_controller

Phase sequencer for a two-way intersection with an optional pedestrian walk phase. It sits directly upstream of the saturation timer: it loads each phase duration into the timer, commands countdown, and advances when the timer count reaches zero. It produces the light outputs for both directions and the walk signal.

## Interface
- COUNT_SIZE, 5, width of the timer count and load value.
- GREEN_TIME, 20, green duration loaded into the timer.
- YELLOW_TIME, 4, yellow duration.
- RED_CLEAR_TIME, 2, all-red clearance duration.
- PED_TIME, 10, walk duration.
- All durations are ≥1 and ≤2^COUNT_SIZE−2; elaboration fails otherwise.
- clk  in  1  the single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- car_ns  in  1  vehicle waiting on the north-south approach; level, sampled every cycle.
- car_ew  in  1  vehicle waiting on the east-west approach; level.
- ped_req  in  1  pedestrian button; a single-cycle pulse is sufficient.
- tmr_count  in  COUNT_SIZE  current timer count.
- tmr_load  out  1  loads tmr_in into the timer on the next edge.
- tmr_down  out  1  decrements the timer on the next edge.
- tmr_in  out  COUNT_SIZE  duration for the current phase.
- ns_light  out  3  one-hot {red,yellow,green} for north-south.
- ew_light  out  3  one-hot {red,yellow,green} for east-west.
- walk  out  1  pedestrian walk indication.
- phase  out  3  state encoding, for debug.

## Operation
- States and encodings: NS_GREEN=0, NS_YELLOW=1, RED_A=2, EW_GREEN=3, EW_YELLOW=4, RED_B=5, PED_WALK=6. Encoding 7 is illegal and is recovered to RED_B with fresh=1.
- Each state has a `fresh` flag that is set on entry. While fresh=1, tmr_load=1, tmr_down=0, and tmr_in equals the duration of the state. While fresh=0, tmr_load=0 and tmr_down=1.
- A state expires when fresh=0 and tmr_count==0. The state does not change on any other condition.
- The integration holds the timer minimum at 0. Saturation at 0 therefore keeps tmr_count stable if an expiry is held.
- Transitions on expiry:
  - NS_GREEN→NS_YELLOW if car_ew or ped_pending is set. Otherwise it stays in NS_GREEN with fresh=1 (green hold, reload).
  - NS_YELLOW→RED_A.
  - RED_A→PED_WALK if ped_pending is set, else EW_GREEN.
  - EW_GREEN→EW_YELLOW if car_ns or ped_pending is set. Otherwise it stays in EW_GREEN with fresh=1.
  - EW_YELLOW→RED_B.
  - RED_B→PED_WALK if ped_pending is set, else NS_GREEN.
  - PED_WALK goes to the green stored in next_dir: EW_GREEN after RED_A, NS_GREEN after RED_B.
- ped_pending is set by ped_req in any cycle. It is cleared on the edge that enters PED_WALK. A ped_req in that same cycle wins, so ped_pending stays set. A ped_req during PED_WALK is therefore serviced at the next all-red.
- Light decode is combinational from state:
  - Green states show green on their own direction and red on the other.
  - Yellow states show yellow on their own direction and red on the other.
  - RED_A, RED_B and PED_WALK show red on both directions.
  - walk=1 only in PED_WALK.
- ns_light and ew_light never show green or yellow at the same time.

## Timing
- While rst=1:
  - state becomes RED_B, fresh=1, ped_pending=0, next_dir=NS.
  - tmr_load=0 and tmr_down=0 are forced.
  - ns_light=ew_light=3'b100, walk=0, phase=5.
- First cycle after reset: tmr_load=1 and tmr_in=RED_CLEAR_TIME.
- Dwell per state visit is DUR+2 cycles: 1 load cycle, DUR decrement cycles, and 1 cycle observing zero.
- A green hold adds another GREEN_TIME+2 cycles per reload.
- Sensor and ped_req inputs are sampled on the expiry cycle only, except ped_req, which is latched every cycle.
- Asserting rst mid-phase aborts the phase on the next edge. No timer command is issued during reset.
- The light and walk outputs change on the same edge as phase. There is no extra latency.

## Configuration
- TRAFFIC_PED_EN defined: pedestrian logic is included as described above.
- TRAFFIC_PED_EN undefined:
  - ped_req is ignored, ped_pending is constant 0, and walk is tied to 0.
  - PED_WALK is unreachable, and encoding 6 is recovered like 7.
  - Green hold depends on the cross-street car input only.

## Test plan
- The bench instantiates the saturation timer with minimum 0, COUNT_SIZE=5, and default durations.
- Reset, then car_ew=car_ns=1, no ped. Required phases: RED_B for 4 cycles, NS_GREEN 22, NS_YELLOW 6, RED_A 4, EW_GREEN 22, EW_YELLOW 6. Loads of 2/20/4/2/20/4.
- car_ew=0, car_ns=1 held in NS_GREEN. NS_GREEN reloads every 22 cycles. Raising car_ew exits on the next expiry to NS_YELLOW.
- ped_req pulse of 1 cycle during NS_GREEN. The path is NS_YELLOW→RED_A→PED_WALK: walk=1 for 12 cycles and both lights red. Then EW_GREEN.
- ped_req asserted in the cycle entering PED_WALK. After EW_YELLOW→RED_B, PED_WALK is visited again before NS_GREEN.
- rst asserted mid EW_GREEN with tmr_count=7. The next edge gives phase=5 and both lights red, with no tmr_load/tmr_down during reset.
- Build without TRAFFIC_PED_EN and pulse ped_req in every state. walk stays 0 and PED_WALK is never entered.

Source files
------------

// File: rtl/traffic_phase_controller.sv
// Two-way intersection phase sequencer driving an external saturating down-timer.
// Optional pedestrian walk phase is included when TRAFFIC_PED_EN is defined.
module traffic_phase_controller #(
    parameter int COUNT_SIZE     = 5,
    parameter int GREEN_TIME     = 20,
    parameter int YELLOW_TIME    = 4,
    parameter int RED_CLEAR_TIME = 2,
    parameter int PED_TIME       = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_car_ns,
    input  logic                  i_car_ew,
    input  logic                  i_ped_req,
    input  logic [COUNT_SIZE-1:0] i_tmr_count,
    output logic                  o_tmr_load,
    output logic                  o_tmr_down,
    output logic [COUNT_SIZE-1:0] o_tmr_in,
    output logic [2:0]            o_ns_light,
    output logic [2:0]            o_ew_light,
    output logic                  o_walk,
    output logic [2:0]            o_phase
);

`ifdef TRAFFIC_PED_EN
    localparam bit P_PED_EN = 1'b1;
`else
    localparam bit P_PED_EN = 1'b0;
`endif

    localparam int P_MAX_DUR = (2 ** COUNT_SIZE) - 2;

    if (GREEN_TIME < 1 || GREEN_TIME > P_MAX_DUR ||
        YELLOW_TIME < 1 || YELLOW_TIME > P_MAX_DUR ||
        RED_CLEAR_TIME < 1 || RED_CLEAR_TIME > P_MAX_DUR ||
        PED_TIME < 1 || PED_TIME > P_MAX_DUR) begin : g_bad_duration
        $error("traffic_phase_controller: phase duration out of range");
    end

    localparam logic [COUNT_SIZE-1:0] L_GREEN  = COUNT_SIZE'(GREEN_TIME);
    localparam logic [COUNT_SIZE-1:0] L_YELLOW = COUNT_SIZE'(YELLOW_TIME);
    localparam logic [COUNT_SIZE-1:0] L_RED    = COUNT_SIZE'(RED_CLEAR_TIME);
    localparam logic [COUNT_SIZE-1:0] L_PED    = COUNT_SIZE'(PED_TIME);

    localparam logic [2:0] L_RED_LT = 3'b100;
    localparam logic [2:0] L_YEL_LT = 3'b010;
    localparam logic [2:0] L_GRN_LT = 3'b001;

    localparam logic [2:0] S_NS_GREEN  = 3'd0;
    localparam logic [2:0] S_NS_YELLOW = 3'd1;
    localparam logic [2:0] S_RED_A     = 3'd2;
    localparam logic [2:0] S_EW_GREEN  = 3'd3;
    localparam logic [2:0] S_EW_YELLOW = 3'd4;
    localparam logic [2:0] S_RED_B     = 3'd5;
    localparam logic [2:0] S_PED_WALK  = 3'd6;

    logic [2:0] r_state;
    logic       r_fresh;
    logic       r_ped_pending;
    logic       r_next_ew;

    logic [2:0] w_state_nxt;
    logic       w_fresh_nxt;
    logic       w_ped_nxt;
    logic       w_next_ew_nxt;
    logic       w_expire;
    logic       w_ped_pend;

    assign w_expire   = !r_fresh && (i_tmr_count == '0);
    assign w_ped_pend = P_PED_EN && r_ped_pending;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_RED_B;
            r_fresh       <= 1'b1;
            r_ped_pending <= 1'b0;
            r_next_ew     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_fresh       <= w_fresh_nxt;
            r_ped_pending <= w_ped_nxt;
            r_next_ew     <= w_next_ew_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_fresh_nxt   = 1'b0;
        w_next_ew_nxt = r_next_ew;
        w_ped_nxt     = r_ped_pending;
        case (r_state)
            S_NS_GREEN: begin
                // Without a cross request the green is simply reloaded.
                if (w_expire) begin
                    w_fresh_nxt = 1'b1;
                    if (i_car_ew || w_ped_pend) w_state_nxt = S_NS_YELLOW;
                end
            end
            S_NS_YELLOW: begin
                if (w_expire) begin
                    w_fresh_nxt = 1'b1;
                    w_state_nxt = S_RED_A;
                end
            end
            S_RED_A: begin
                if (w_expire) begin
                    w_fresh_nxt = 1'b1;
                    if (w_ped_pend) begin
                        w_state_nxt   = S_PED_WALK;
                        w_next_ew_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_EW_GREEN;
                    end
                end
            end
            S_EW_GREEN: begin
                if (w_expire) begin
                    w_fresh_nxt = 1'b1;
                    if (i_car_ns || w_ped_pend) w_state_nxt = S_EW_YELLOW;
                end
            end
            S_EW_YELLOW: begin
                if (w_expire) begin
                    w_fresh_nxt = 1'b1;
                    w_state_nxt = S_RED_B;
                end
            end
            S_RED_B: begin
                if (w_expire) begin
                    w_fresh_nxt = 1'b1;
                    if (w_ped_pend) begin
                        w_state_nxt   = S_PED_WALK;
                        w_next_ew_nxt = 1'b0;
                    end else begin
                        w_state_nxt = S_NS_GREEN;
                    end
                end
            end
            S_PED_WALK: begin
                if (!P_PED_EN) begin
                    w_fresh_nxt = 1'b1;
                    w_state_nxt = S_RED_B;
                end else if (w_expire) begin
                    w_fresh_nxt = 1'b1;
                    w_state_nxt = r_next_ew ? S_EW_GREEN : S_NS_GREEN;
                end
            end
            default: begin
                w_fresh_nxt = 1'b1;
                w_state_nxt = S_RED_B;
            end
        endcase
        // A request arriving on the entry edge survives the clear.
        if (w_state_nxt == S_PED_WALK && r_state != S_PED_WALK) w_ped_nxt = 1'b0;
        w_ped_nxt = P_PED_EN && (w_ped_nxt || i_ped_req);
    end

    always_comb begin
        o_tmr_load = !i_rst && r_fresh;
        o_tmr_down = !i_rst && !r_fresh;
        o_tmr_in   = L_RED;
        o_ns_light = L_RED_LT;
        o_ew_light = L_RED_LT;
        o_walk     = 1'b0;
        o_phase    = r_state;
        case (r_state)
            S_NS_GREEN: begin
                o_tmr_in   = L_GREEN;
                o_ns_light = L_GRN_LT;
            end
            S_NS_YELLOW: begin
                o_tmr_in   = L_YELLOW;
                o_ns_light = L_YEL_LT;
            end
            S_EW_GREEN: begin
                o_tmr_in   = L_GREEN;
                o_ew_light = L_GRN_LT;
            end
            S_EW_YELLOW: begin
                o_tmr_in   = L_YELLOW;
                o_ew_light = L_YEL_LT;
            end
            S_PED_WALK: begin
                o_tmr_in = L_PED;
                o_walk   = P_PED_EN;
            end
            default: begin
                o_tmr_in = L_RED;
            end
        endcase
    end

endmodule
